// File: rtl/axi_lite_master_pkg.sv
// Shared types and constants for the AXI4-Lite master.
package axi_lite_master_pkg;

   // Transaction sequencer states.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_DATA = 3'd4,
      RESP    = 3'd5
   } state_t;

   // Default watchdog limit, in cycles spent in a single wait state.
   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/axi_lite_master_if.sv
// Client command/response channel plus the AXI4-Lite AW/W/B/AR/R subset.
// Handshake rule on every channel: a transfer happens on the rising clock edge
// where both valid and ready are high; the source keeps valid and its payload
// stable until that edge, and ready may be high before valid arrives.
interface axi_lite_master_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
);
   // client side
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic                    cmd_write;
   logic [ADDR_WIDTH-1:0]   cmd_addr;
   logic [DATA_WIDTH-1:0]   cmd_wdata;
   logic [DATA_WIDTH/8-1:0] cmd_wstrb;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [DATA_WIDTH-1:0]   rsp_rdata;
   logic                    rsp_err;
   // AXI side
   logic [ADDR_WIDTH-1:0]   AWADDR;
   logic                    AWVALID;
   logic                    AWREADY;
   logic [DATA_WIDTH-1:0]   WDATA;
   logic [DATA_WIDTH/8-1:0] WSTRB;
   logic                    WVALID;
   logic                    WREADY;
   logic                    BVALID;
   logic                    BREADY;
   logic [ADDR_WIDTH-1:0]   ARADDR;
   logic                    ARVALID;
   logic                    ARREADY;
   logic [DATA_WIDTH-1:0]   RDATA;
   logic                    RVALID;
   logic                    RREADY;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
      input  AWREADY, WREADY, BVALID, ARREADY, RDATA, RVALID,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
      output AWREADY, WREADY, BVALID, ARREADY, RDATA, RVALID,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY
   );
endinterface

// File: rtl/axi_lite_timeout_ctr.sv
// Wait-state watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches LIMIT.
module axi_lite_timeout_ctr #(
   parameter int LIMIT = 16
) (
   input  logic ACLK,
   input  logic ARESET,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q;

   // Expiry is combinational on the count so the sequencer can leave the wait
   // state on the same edge that completes the LIMIT-th cycle.
   assign expired = enable && (cnt_q == CW'(LIMIT - 1));

   // Cycle counter, restarted on every state change.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)                     cnt_q <= '0;
      else if (clear)                 cnt_q <= '0;
      else if (enable && !expired)    cnt_q <= cnt_q + 1'b1;
   end
endmodule

// File: rtl/axi_lite_master.sv
// AXI4-Lite master: one client command in, one AXI transaction out, one
// response back. Optional watchdog enabled with macro AXI_MASTER_TIMEOUT_EN.
// All bus/client outputs come straight from flops.
module axi_lite_master
   import axi_lite_master_pkg::*;
#(
   parameter int ADDR_WIDTH     = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   axi_lite_master_if.master        bus,
   output state_t                   dbg_state
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    bready_q, bready_d;
   logic                    arvalid_q, arvalid_d;
   logic                    rready_q, rready_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

`ifdef AXI_MASTER_TIMEOUT_EN
   logic err_q, err_d;
   logic expired;
   logic in_wait;

   assign in_wait = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                    (state_q == RD_REQ) || (state_q == RD_DATA);

   axi_lite_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .ACLK    (ACLK),
      .ARESET  (ARESET),
      .clear   (state_d != state_q),
      .enable  (in_wait),
      .expired (expired)
   );

   assign bus.rsp_err = err_q;
`else
   assign bus.rsp_err = 1'b0;
`endif

   // Next state and next registered outputs; the direction of the command is
   // carried by the state itself, so only the payload is latched.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      rsp_valid_d = rsp_valid_q;
      rdata_d     = rdata_q;
`ifdef AXI_MASTER_TIMEOUT_EN
      err_d       = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               addr_d  = bus.cmd_addr;
               wdata_d = bus.cmd_wdata;
               wstrb_d = bus.cmd_wstrb;
               if (bus.cmd_write) begin
                  state_d   = WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = RD_REQ;
                  arvalid_d = 1'b1;
               end
            end
         end
         WR_REQ: begin
            // AW and W retire independently; move on once both are gone.
            if (awvalid_q && bus.AWREADY) awvalid_d = 1'b0;
            if (wvalid_q && bus.WREADY)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               state_d  = WR_RESP;
               bready_d = 1'b1;
            end
         end
         WR_RESP: begin
            if (bus.BVALID && bready_q) begin
               bready_d    = 1'b0;
               rdata_d     = '0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RD_REQ: begin
            if (arvalid_q && bus.ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (bus.RVALID && rready_q) begin
               rready_d    = 1'b0;
               rdata_d     = bus.RDATA;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
               err_d       = 1'b0;
`endif
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef AXI_MASTER_TIMEOUT_EN
      // Watchdog abandons the transaction and reports an error response.
      if (expired) begin
         awvalid_d   = 1'b0;
         wvalid_d    = 1'b0;
         bready_d    = 1'b0;
         arvalid_d   = 1'b0;
         rready_d    = 1'b0;
         rdata_d     = '0;
         rsp_valid_d = 1'b1;
         err_d       = 1'b1;
         state_d     = RESP;
      end
`endif
      cmd_ready_d = (state_d == IDLE);
   end

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         cmd_ready_q <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
`ifdef AXI_MASTER_TIMEOUT_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         cmd_ready_q <= cmd_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
`ifdef AXI_MASTER_TIMEOUT_EN
         err_q       <= err_d;
`endif
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.AWADDR    = addr_q;
   assign bus.AWVALID   = awvalid_q;
   assign bus.WDATA     = wdata_q;
   assign bus.WSTRB     = wstrb_q;
   assign bus.WVALID    = wvalid_q;
   assign bus.BREADY    = bready_q;
   assign bus.ARADDR    = addr_q;
   assign bus.ARVALID   = arvalid_q;
   assign bus.RREADY    = rready_q;
   assign dbg_state     = state_q;
endmodule
